// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - Oversampling constants (OVERSAMPLE, MID_SAMPLE, DATA_BITS)
//   - Receiver FSM state encodings
//   - uart_divisor(): clocks per oversample tick, also used by the
//     transmitter baud generator
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    function automatic int unsigned uart_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud,
                                                 input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: free-running oversample tick generator.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   tick - one-cycle pulse every DIVISOR clocks (every clock when DIVISOR=1)
module uart_rx_tick_gen #(
    parameter int unsigned DIVISOR = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIVISOR - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive path, 8 data bits LSB first.
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit).
//   clk           - system clock, rising edge
//   rst           - asynchronous active-low reset
//   RxD           - serial line, idle high, asynchronous to clk
//   rd_ack        - host consumes rx_data; clears data_ready and overrun
//   rx_data       - last good received byte
//   data_ready    - a byte is held and not yet acknowledged
//   busy          - receiver is not idle
//   framing_error - one-cycle pulse, stop bit sampled low
//   overrun       - sticky, a byte completed while data_ready was high
//   parity_error  - one-cycle pulse, parity mismatch (0 without parity)
module uart_receiver #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIVISOR    = uart_pkg::uart_divisor(CLK_FREQ, BAUD, OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       busy,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    import uart_pkg::*;

    logic       tick;
    logic [1:0] sync_q;
    logic       rxs;

    logic [2:0] state_q, state_d;
    logic [3:0] ph_q, ph_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       dr_q, dr_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       perr_q, perr_d;
`endif

    uart_rx_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rxs = sync_q[1];

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        dr_d      = dr_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (rd_ack) begin
            dr_d  = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    ph_d    = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (ph_q == 4'(MID_SAMPLE - 1)) begin
                        // A start bit already high again at mid-bit is a glitch.
                        if (rxs) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                            ph_d      = '0;
                        end
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (ph_q == 4'(OVERSAMPLE - 1)) begin
                        ph_d    = '0;
                        shift_d = {rxs, shift_q[7:1]};
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (ph_q == 4'(OVERSAMPLE - 1)) begin
                        ph_d      = '0;
                        par_bad_d = ^{shift_q, rxs};
                        state_d   = ST_STOP;
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (ph_q == 4'(OVERSAMPLE - 1)) begin
                        ph_d = '0;
`ifdef UART_RX_PARITY_EN
                        if (rxs && !par_bad_q) begin
`else
                        if (rxs) begin
`endif
                            rx_data_d = shift_q;
                            dr_d      = 1'b1;
                            // A simultaneous ack consumes the old byte, so no overrun.
                            if (dr_q && !rd_ack) ovr_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d = !rxs;
`ifdef UART_RX_PARITY_EN
                            perr_d = par_bad_q;
`endif
                            state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
                        end
                    end else begin
                        ph_d = ph_q + 4'd1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            dr_q      <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], RxD};
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            dr_q      <= dr_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = dr_q;
    assign busy          = (state_q != ST_IDLE);
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       RxD;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       busy;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned fe_cnt = 0;
    int unsigned pe_cnt = 0;

    logic [7:0] sb[$];
    logic       dr_prev = 1'b0;
    logic [7:0] rx_prev = 8'h00;

    uart_receiver #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .RxD           (RxD),
        .rd_ack        (rd_ack),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun),
        .parity_error  (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Error pulse counters and byte scoreboard, all sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (framing_error === 1'b1) fe_cnt++;
            if (parity_error === 1'b1)  pe_cnt++;
            if (data_ready === 1'b1 && (!dr_prev || rx_data !== rx_prev)) begin
                if (sb.size() == 0) check("sb_unexpected_byte", {24'd0, rx_data}, 32'h100);
                else                check("rx_byte", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
        end
        dr_prev = data_ready;
        rx_prev = rx_data;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^d;
        f[10]  = stop;
`else
        f[9]   = stop;
`endif
        return f;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            RxD = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(make_frame(d, stop), FRAME_BITS);
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] f;
        int unsigned fe_base;

        rst    = 1'b0;
        RxD    = 1'b1;
        rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_data_ready", {31'd0, data_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_framing_error", {31'd0, framing_error}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_parity_error", {31'd0, parity_error}, 32'd0);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        // Good 0x55 frame, no ack.
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check("b55_data_ready", {31'd0, data_ready}, 32'd1);
        check("b55_rx_data", {24'd0, rx_data}, 32'h55);
        check("b55_overrun", {31'd0, overrun}, 32'd0);
        check("b55_fe_cnt", fe_cnt, 32'd0);
        check("b55_busy", {31'd0, busy}, 32'd0);
        ack_pulse();
        check("b55_ack_data_ready", {31'd0, data_ready}, 32'd0);

        // Short low glitch on the line.
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_start", {31'd0, busy}, 32'd1);
        repeat (12) @(negedge clk);
        check("glitch_busy_idle", {31'd0, busy}, 32'd0);
        check("glitch_data_ready", {31'd0, data_ready}, 32'd0);
        check("glitch_fe_cnt", fe_cnt, 32'd0);

        // 0xA3 with a low stop bit followed by a held break.
        send_frame(8'hA3, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_fe_cnt", fe_cnt, 32'd1);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        check("brk_rx_data", {24'd0, rx_data}, 32'h55);
        check("brk_data_ready", {31'd0, data_ready}, 32'd0);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_busy_released", {31'd0, busy}, 32'd0);
        check("brk_fe_cnt_after", fe_cnt, 32'd1);

        // Back-to-back 0x12, 0x34 without ack.
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        sb.push_back(8'h34);
        send_frame(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_rx_data", {24'd0, rx_data}, 32'h34);
        check("ovr_data_ready", {31'd0, data_ready}, 32'd1);
        check("ovr_overrun", {31'd0, overrun}, 32'd1);
        ack_pulse();
        check("ovr_ack_data_ready", {31'd0, data_ready}, 32'd0);
        check("ovr_ack_overrun", {31'd0, overrun}, 32'd0);

        // Ack lands in the completion cycle of the second byte.
        sb.push_back(8'h56);
        send_frame(8'h56, 1'b1);
        sb.push_back(8'h78);
        f = make_frame(8'h78, 1'b1);
        send_bits(f, FRAME_BITS - 1);
        RxD = 1'b1;
        repeat (10) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("coin_data_ready", {31'd0, data_ready}, 32'd1);
        check("coin_overrun", {31'd0, overrun}, 32'd0);
        check("coin_rx_data", {24'd0, rx_data}, 32'h78);
        ack_pulse();
        check("coin_ack_data_ready", {31'd0, data_ready}, 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a parity bit of 1.
        f = make_frame(8'h07, 1'b1);
        f[9] = 1'b0;
        send_bits(f, FRAME_BITS);
        repeat (4) @(negedge clk);
        check("par_bad_pe_cnt", pe_cnt, 32'd1);
        check("par_bad_data_ready", {31'd0, data_ready}, 32'd0);
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        repeat (4) @(negedge clk);
        check("par_ok_pe_cnt", pe_cnt, 32'd1);
        check("par_ok_data_ready", {31'd0, data_ready}, 32'd1);
        check("par_ok_rx_data", {24'd0, rx_data}, 32'h07);
        ack_pulse();
`else
        check("nopar_pe_cnt", pe_cnt, 32'd0);
`endif

        // Reset in the middle of a frame aborts it without side effects.
        fe_base = fe_cnt;
        RxD = 1'b0;
        repeat (16) @(negedge clk);
        RxD = 1'b1;
        repeat (16) @(negedge clk);
        RxD = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_busy_async", {31'd0, busy}, 32'd0);
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);
        check("midrst_data_ready", {31'd0, data_ready}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        check("midrst_fe_cnt", fe_cnt, fe_base);

        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path for the master control link, the counterpart of the existing UART transmitter FSM. It oversamples the serial input at 16× baud and validates the start bit at mid-bit. It shifts in 8 data bits LSB first and checks the stop bit. The received byte is held for the host logic under a ready/acknowledge handshake, with framing and overrun error reporting.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line baud rate.
- OVERSAMPLE, 16: ticks per bit; fixed at 16 (bit-phase counter is 4 bits).
- DIVISOR, CLK_FREQ/(BAUD*OVERSAMPLE): clocks per oversample tick, integer division, must be ≥1.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- RxD  input  1  serial line, idle high, asynchronous to clk.
- rd_ack  input  1  host consumes rx_data; clears data_ready.
- rx_data  output  8  last good received byte.
- data_ready  output  1  level; a byte is held and not yet acknowledged.
- busy  output  1  high in every state except IDLE.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky; a byte completed while data_ready was high; cleared by rd_ack.
- parity_error  output  1  one-cycle pulse (only with UART_RX_PARITY_EN; else tied 0).

## Operation
- RxD passes through a 2-FF synchronizer (reset value 1). All logic uses the synchronized value rxs.
- Tick generator: counter 0..DIVISOR-1. It emits a one-cycle tick on terminal count and always runs.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rxs==0, go to START and clear the phase counter.
- START: count 8 ticks to reach mid-bit, then sample. If rxs==0, go to DATA, clear bit_cnt and the phase counter. If rxs==1, treat it as a glitch and return to IDLE with no error.
- DATA: every 16 ticks, shift rxs into the MSB of shift_reg (right shift). After the 8th bit, go to STOP (or PARITY when enabled).
- PARITY: after 16 ticks, sample; even parity over the 8 data bits plus the parity bit is required.
- STOP: after 16 ticks, sample.
  - If rxs==1 and there was no parity error: rx_data<=shift_reg. Set data_ready. If data_ready was already set and rd_ack is not high in the same cycle, set overrun (the new byte still overwrites). Return to IDLE.
  - If rxs==0: pulse framing_error, leave rx_data and data_ready unchanged, go to WAIT_HIGH.
  - If parity failed: pulse parity_error and discard the byte. Go to IDLE if rxs==1, else WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a break condition from retriggering reception.
- rd_ack clears data_ready and overrun on the next edge. If rd_ack and byte completion coincide, the new byte wins: data_ready=1, overrun=0.

## Timing
- Reset values: rx_data=0, data_ready=0, busy=0, framing_error=0, overrun=0, parity_error=0. FSM=IDLE, counters=0.
- A reset mid-frame aborts immediately. No pulse is emitted after reset deassertion.
- Start-bit detect latency: 2 clk (synchronizer) + ≤1 clk.
- data_ready rises 1 clk after the mid-stop sample tick. It is registered; there are no combinational paths from inputs to outputs.
- Sample points: 8, 24, 40 … ticks after the detected falling edge. This gives ±7/16 bit tolerance.
- busy falls in the same cycle the FSM enters IDLE.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists and a frame is 11 bits (start, 8 data, even parity, stop). parity_error is live.
- Not defined: the PARITY state and its logic are absent. A frame is 10 bits and parity_error is constant 0.

## Structure
- Shared package uart_pkg holds:
  - FSM state encodings.
  - OVERSAMPLE, MID_SAMPLE=8, DATA_BITS=8.
  - The divisor function, shared with the transmitter baud generator.
- One sub-module, uart_rx_tick_gen: parameter DIVISOR, inputs clk and rst, output tick.
- FSM, shift register and handshake stay in uart_receiver.

## Test plan
Use CLK_FREQ=1_600_000 and BAUD=100_000, so DIVISOR=1 and a bit lasts 16 clk.
- Frame 0x55 with a good stop, no ack → rx_data=0x55, data_ready=1, framing_error and overrun stay 0; rd_ack → data_ready=0.
- RxD low pulse of 4 clk → FSM returns to IDLE, data_ready stays 0, no error pulse.
- Frame 0xA3 with stop bit low, then line held low 40 clk → one framing_error pulse, rx_data unchanged, busy held until the line returns high.
- 0x12 then 0x34 back-to-back with no ack → rx_data=0x34, overrun=1; rd_ack clears both flags.
- rd_ack asserted in the completion cycle of the second byte → data_ready=1, overrun=0.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_error pulse, data_ready=0; with parity bit 1 → data accepted.
